conditional_sum_adder_4bit: RTL and testbench



---
 rtl/csa_pkg.sv | 47 ++++
 rtl/csa_merge.sv | 35 +++
 rtl/conditional_sum_adder_4bit.sv | 130 +++++++++++++
 tb/tb_conditional_sum_adder_4bit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// ============================================================================
// Module   : csa_pkg
// Brief    : Shared width, candidate-pair types and helpers for the
//            conditional-sum adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  localparam int CSA_WIDTH = 4;

  typedef struct packed {
    logic sum;
    logic carry;
  } csa_pair_t;

  // Candidate results of one bit for both possible incoming carries.
  typedef struct packed {
    csa_pair_t cin0;
    csa_pair_t cin1;
  } csa_cand_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic csa_cand_t csa_bit_cand(input logic a, input logic b);
    csa_cand_t c;
    c.cin0.sum   = a ^ b;
    c.cin0.carry = a & b;
    c.cin1.sum   = ~(a ^ b);
    c.cin1.carry = a | b;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_merge.sv
// ============================================================================
// Module   : csa_merge
// Brief    : Merges two adjacent GW-bit candidate groups into one 2*GW-bit
//            group; the lower group's carries select the upper candidates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_merge
  import csa_pkg::*;
#(
  parameter int GW = 1
) (
  input  logic [GW-1:0]   lo_s0,
  input  logic [GW-1:0]   lo_s1,
  input  logic            lo_c0,
  input  logic            lo_c1,
  input  logic [GW-1:0]   hi_s0,
  input  logic [GW-1:0]   hi_s1,
  input  logic            hi_c0,
  input  logic            hi_c1,
  output logic [2*GW-1:0] s0,
  output logic [2*GW-1:0] s1,
  output logic            c0,
  output logic            c1
);

  assign s0 = {(lo_c0 ? hi_s1 : hi_s0), lo_s0};
  assign c0 = lo_c0 ? hi_c1 : hi_c0;
  assign s1 = {(lo_c1 ? hi_s1 : hi_s0), lo_s1};
  assign c1 = lo_c1 ? hi_c1 : hi_c0;

endmodule

`default_nettype wire

// File: rtl/conditional_sum_adder_4bit.sv
// ============================================================================
// Module   : conditional_sum_adder_4bit
// Brief    : Registered conditional-sum adder, S/C_out = A + B + C_in.
//            Optional macro CSA_INPUT_REG_EN adds an input register stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conditional_sum_adder_4bit
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int LEVELS = clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef CSA_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;

  always_comb begin
    a_d   = A;
    b_d   = B;
    cin_d = C_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = A;
  assign op_b   = B;
  assign op_cin = C_in;
`endif

  // Level k holds WIDTH>>k groups of 2^k bits, each with both carry-in variants.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int G  = 1 << k;
    localparam int NG = WIDTH >> k;

    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    logic [NG-1:0]    c0;
    logic [NG-1:0]    c1;

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        csa_cand_t cand;
        assign cand  = csa_bit_cand(op_a[i], op_b[i]);
        assign s0[i] = cand.cin0.sum;
        assign c0[i] = cand.cin0.carry;
        assign s1[i] = cand.cin1.sum;
        assign c1[i] = cand.cin1.carry;
      end
    end else begin : g_tree
      localparam int H = G / 2;
      for (genvar j = 0; j < NG; j++) begin : g_grp
        csa_merge #(
          .GW(H)
        ) u_merge (
          .lo_s0 (g_lvl[k-1].s0[j*G +: H]),
          .lo_s1 (g_lvl[k-1].s1[j*G +: H]),
          .lo_c0 (g_lvl[k-1].c0[2*j]),
          .lo_c1 (g_lvl[k-1].c1[2*j]),
          .hi_s0 (g_lvl[k-1].s0[j*G+H +: H]),
          .hi_s1 (g_lvl[k-1].s1[j*G+H +: H]),
          .hi_c0 (g_lvl[k-1].c0[2*j+1]),
          .hi_c1 (g_lvl[k-1].c1[2*j+1]),
          .s0    (s0[j*G +: G]),
          .s1    (s1[j*G +: G]),
          .c0    (c0[j]),
          .c1    (c1[j])
        );
      end
    end
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;

  always_comb begin
    s_d     = g_lvl[LEVELS].s0;
    c_out_d = g_lvl[LEVELS].c0[0];
    if (op_cin) begin
      s_d     = g_lvl[LEVELS].s1;
      c_out_d = g_lvl[LEVELS].c1[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
    end
  end

  assign S     = s_q;
  assign C_out = c_out_q;

endmodule

`default_nettype wire

// File: tb/tb_conditional_sum_adder_4bit.sv
// ============================================================================
// Module   : tb_conditional_sum_adder_4bit
// Brief    : Scoreboard bench for conditional_sum_adder_4bit (honours
//            CSA_INPUT_REG_EN for the pipeline latency).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conditional_sum_adder_4bit;

`ifdef CSA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       C_in;
  logic [3:0] S;
  logic       C_out;

  conditional_sum_adder_4bit #(
    .WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: target edge number, expected {C_out,S}, label.
  int         q_tgt[$];
  logic [4:0] q_val[$];
  string      q_name[$];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic push(input int tgt, input logic [4:0] v, input string name);
    q_tgt.push_back(tgt);
    q_val.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic [4:0] exp, input string name);
    @(negedge clk);
    rst  = r;
    A    = a;
    B    = b;
    C_in = ci;
    if (r) begin
      q_tgt.delete();
      q_val.delete();
      q_name.delete();
      push(cyc + 1, 5'd0, name);
      if (LAT == 2) push(cyc + 2, 5'd0, name);
    end else begin
      push(cyc + LAT, exp, name);
    end
  endtask

  // Monitor: one output sample per edge, well after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      while (q_tgt.size() > 0 && q_tgt[0] < cyc) begin
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL %s: result never checked at edge %0d (now %0d)", q_name[0], q_tgt[0], cyc);
        void'(q_tgt.pop_front());
        void'(q_val.pop_front());
        void'(q_name.pop_front());
      end
      if (q_tgt.size() > 0 && q_tgt[0] == cyc) begin
        logic [4:0] e;
        string      nm;
        e  = q_val.pop_front();
        nm = q_name.pop_front();
        void'(q_tgt.pop_front());
        n_tests = n_tests + 1;
        if ({C_out, S} !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL %s @edge %0d: got C_out=%0b S=%0d, expected C_out=%0b S=%0d",
                   nm, cyc, C_out, S, e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    A    = 4'd15;
    B    = 4'd15;
    C_in = 1'b1;

    drive(1'b1, 4'd15, 4'd15, 1'b1, 5'd0,  "reset_hold0");
    drive(1'b1, 4'd15, 4'd15, 1'b1, 5'd0,  "reset_hold1");
    drive(1'b0, 4'd15, 4'd15, 1'b1, 5'd31, "reset_release");

    drive(1'b0, 4'd3,  4'd10, 1'b1, 5'd14, "3+10+1");
    drive(1'b0, 4'd3,  4'd11, 1'b0, 5'd14, "3+11+0");
    drive(1'b0, 4'd12, 4'd10, 1'b1, 5'd23, "12+10+1");
    drive(1'b0, 4'd13, 4'd10, 1'b1, 5'd24, "13+10+1");
    drive(1'b0, 4'd8,  4'd8,  1'b1, 5'd17, "8+8+1");
    drive(1'b0, 4'd15, 4'd15, 1'b1, 5'd31, "b2b_max");
    drive(1'b0, 4'd0,  4'd0,  1'b0, 5'd0,  "b2b_zero");
    drive(1'b0, 4'd15, 4'd0,  1'b1, 5'd16, "15+0+1");
    drive(1'b0, 4'd7,  4'd8,  1'b0, 5'd15, "7+8+0");

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] ref_sum;
      v       = i[8:0];
      ref_sum = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
      if (i == 200) drive(1'b1, v[8:5], v[4:1], v[0], 5'd0, "midstream_reset");
      drive(1'b0, v[8:5], v[4:1], v[0], ref_sum, "exhaustive");
    end

    @(negedge clk);
    A    = 4'd0;
    B    = 4'd0;
    C_in = 1'b0;
    for (int w = 0; w < 10 && q_tgt.size() > 0; w++) @(negedge clk);
    n_tests = n_tests + 1;
    if (q_tgt.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d results outstanding, expected 0", q_tgt.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
